asrv32_clint: RTL
=================

Name: asrv32_clint

Overview:
- Parametrised core-local interruptor. Replaces the per-core external mtime/mtimecmp write strobes with a memory-mapped timer block serving NUM_HARTS cores.
- Holds one shared 64-bit mtime with a prescaler, plus a 64-bit mtimecmp and an msip bit per hart.
- Drives per-hart timer and software interrupt lines.
- Sits on the data bus beside RAM. The register map is CLINT-compatible.

Parameters:
- NUM_HARTS, 1, number of harts served (1..16).
- PRESCALE, 1, i_clk cycles per mtime increment (>=1).
- ADDR_W, 16, byte-offset address width decoded inside the block.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_req  in  1  bus request, single-cycle pulse per access.
- i_wr_en  in  1  1 = write, 0 = read (qualified by i_req).
- i_addr  in  ADDR_W  byte offset. Bits [1:0] are ignored.
- i_wdata  in  32  write data.
- i_wr_mask  in  4  byte enables {b3,b2,b1,b0}.
- o_ack  out  1  response strobe, exactly one per accepted request.
- o_rdata  out  32  read data, valid while o_ack=1.
- o_mtime  out  64  current mtime.
- o_mtip  out  NUM_HARTS  timer interrupt pending per hart.
- o_msip  out  NUM_HARTS  software interrupt pending per hart.

Behaviour:
- Reset (i_rst=1 at a rising edge) puts every register in its reset state on that edge:
  - mtime=0, prescaler=0, every mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0.
  - o_ack=0, o_rdata=0, o_mtip=0.
  - A request in the reset cycle is dropped (no ack).
- Register map (h = hart index):
  - msip[h] at 0x0000+4h. Only bit 0 is writable; reads return {31'b0,msip}.
  - mtimecmp[h] low word at 0x4000+8h, high word at 0x4004+8h.
  - mtime low word at 0xBFF8, high word at 0xBFFC.
  - An h >= NUM_HARTS, or any other offset, is unmapped: the read returns 0, the write is ignored, o_ack is still given.
- Handshake:
  - i_req sampled high at edge N produces o_ack=1 during cycle N+1 only.
  - o_rdata is registered. It is updated with the read value when o_ack is asserted and otherwise returns to 0.
  - Back-to-back requests on consecutive cycles are legal; each gets its own ack.
  - A write ack carries o_rdata=0.
- Writes:
  - Byte-granular per i_wr_mask. Masked bytes keep their old value. i_wr_mask=0 is a legal no-op that is still acked.
  - Write data takes effect at the request edge, so a read in the following cycle returns the new value.
- Prescaler:
  - Counts 0..PRESCALE-1, wrapping to 0.
  - mtime increments by 1 on the edge where prescaler==PRESCALE-1. PRESCALE=1 means increment every cycle.
  - mtime wraps from 2^64-1 to 0.
  - The low-to-high carry is a native 64-bit add, with no split-word race internally.
- Simultaneous mtime write and increment:
  - The written bytes take the written value. No increment is applied that cycle, including to the unwritten word.
  - The prescaler keeps counting.
- Reads of mtime return the value before the edge's update. For each word separately, the read data is the register value at the request edge.
- o_mtip[h] is registered: o_mtip[h] <= (mtime >= mtimecmp[h]), unsigned 64-bit compare using the post-update values of that edge. The output therefore reflects the new state one cycle after any write or increment. It is level, cleared only by raising mtimecmp or lowering mtime.
- o_msip[h] is a direct register output.
- No internal FSM beyond the ack pipeline and prescaler. All outputs come from flops; there is no combinational path from the bus inputs to the outputs.

Test Plan:
- Reset, idle 5 cycles with PRESCALE=1 -> o_mtime=5, o_mtip=0, o_msip=0. Read 0x4000 -> ack one cycle later, o_rdata=32'hFFFF_FFFF.
- PRESCALE=4: release reset, sample o_mtime every cycle -> it increments on cycles 4, 8, 12, …, giving 3 after 12 cycles.
- NUM_HARTS=2, mtimecmp[1]=64'd20 (writes to 0x4008 and 0x400C=0) -> o_mtip[1] rises the cycle after mtime reaches 20, o_mtip[0] stays 0. Then write 0x4008=100 -> o_mtip[1] falls one cycle later.
- Write 0xBFF8=32'hFFFF_FFFF and 0xBFFC=0 -> two cycles later o_mtime=64'h1_0000_0000 (carry). Write 0xBFFC with mask 4'b0010, data 32'h0000_AB00 -> only byte 1 of the high word changes.
- Write 0x0004=32'hFFFF_FFFF with NUM_HARTS=2 -> o_msip=2'b10; read back 0x0004=1. Access 0x0008 (unmapped) -> read 0, ack given, state unchanged.
- Assert i_rst for one cycle while mtime=1000 and a read ack is pending -> next cycle o_ack=0, o_mtime=0, all mtimecmp reset to all-ones.

Source files
------------

// File: rtl/asrv32_clint.sv
// asrv32_clint: CLINT-compatible shared mtime with prescaler plus per-hart mtimecmp/msip
module asrv32_clint #(
  parameter int NUM_HARTS = 1,
  parameter int PRESCALE = 1,
  parameter int ADDR_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req,
  input  logic                 i_wr_en,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [31:0]          i_wdata,
  input  logic [3:0]           i_wr_mask,
  output logic                 o_ack,
  output logic [31:0]          o_rdata,
  output logic [63:0]          o_mtime,
  output logic [NUM_HARTS-1:0] o_mtip,
  output logic [NUM_HARTS-1:0] o_msip
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre;
  logic [63:0] mtime, mtime_nx;
  logic [63:0] cmp [NUM_HARTS];
  logic [63:0] cmp_nx [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip, msip_nx, mtip_nx;
  logic [ADDR_W-1:0] off;
  logic [31:0] rd, bm;
  logic tick, wr, mt_lo, mt_hi;
  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d, input logic [31:0] m);
    return (o & ~m) | (d & m);
  endfunction
  assign off = {i_addr[ADDR_W-1:2], 2'b00};
  assign bm = {{8{i_wr_mask[3]}}, {8{i_wr_mask[2]}}, {8{i_wr_mask[1]}}, {8{i_wr_mask[0]}}};
  assign wr = i_req && i_wr_en;
  assign tick = pre == PW'(PRESCALE - 1);
  assign mt_lo = off == ADDR_W'(32'hBFF8);
  assign mt_hi = off == ADDR_W'(32'hBFFC);
  always_comb begin
    mtime_nx = (wr && mt_lo) ? {mtime[63:32], mrg(mtime[31:0], i_wdata, bm)} :
               (wr && mt_hi) ? {mrg(mtime[63:32], i_wdata, bm), mtime[31:0]} :
               tick ? mtime + 64'd1 : mtime;
    rd = mt_lo ? mtime[31:0] : mt_hi ? mtime[63:32] : 32'd0;
    msip_nx = msip;
    cmp_nx = cmp;
    mtip_nx = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (off == ADDR_W'(4 * h)) begin
        rd = {31'd0, msip[h]};
        msip_nx[h] = (wr && i_wr_mask[0]) ? i_wdata[0] : msip[h];
      end
      if (off == ADDR_W'(32'h4000 + 8 * h)) begin
        rd = cmp[h][31:0];
        cmp_nx[h][31:0] = wr ? mrg(cmp[h][31:0], i_wdata, bm) : cmp[h][31:0];
      end
      if (off == ADDR_W'(32'h4004 + 8 * h)) begin
        rd = cmp[h][63:32];
        cmp_nx[h][63:32] = wr ? mrg(cmp[h][63:32], i_wdata, bm) : cmp[h][63:32];
      end
      mtip_nx[h] = mtime_nx >= cmp_nx[h];
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtime <= '0;
      pre <= '0;
      msip <= '0;
      o_ack <= 1'b0;
      o_rdata <= '0;
      o_mtip <= '0;
      for (int h = 0; h < NUM_HARTS; h++) cmp[h] <= '1;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      mtime <= mtime_nx;
      cmp <= cmp_nx;
      msip <= msip_nx;
      o_mtip <= mtip_nx;
      o_ack <= i_req;
      o_rdata <= (i_req && !i_wr_en) ? rd : 32'd0;
    end
  end
  assign o_mtime = mtime;
  assign o_msip = msip;
endmodule
